// File: rtl/text_ram_arbiter.sv
// Arbitrates the text-overlay character RAM between display fetch, the host write port
// and the screen-clear sweep. Fixed priority: display > clear > host.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no sweep running; host writes may be granted
// S_CLEAR | sweep writes CLR_CHAR to 0..COLS*ROWS-1, stalled by display
module text_ram_arbiter #(
    parameter int                COLS     = 40,
    parameter int                ROWS     = 40,
    parameter int                ADDR_W   = 11,
    parameter int                DATA_W   = 7,
    parameter logic [DATA_W-1:0] CLR_CHAR = 7'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [5:0]        disp_col,
    input  logic [5:0]        disp_row,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int                CELLS     = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_last;
    logic              gnt_disp;
    logic              gnt_clr;
    logic              gnt_host;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_oob;
    logic              wr_in_range;
    logic              pipe_v1;
    logic              pipe_v2;
    logic              pipe_oob1;
    logic              pipe_oob2;

    assign disp_addr   = ADDR_W'(disp_row) * ADDR_W'(COLS) + ADDR_W'(disp_col);
    assign disp_oob    = (32'(disp_col) >= 32'(COLS)) || (32'(disp_row) >= 32'(ROWS));
    assign wr_in_range = 32'(wr_addr) < 32'(CELLS);
    assign clr_last    = (clr_cnt == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (clr_start) state_nxt = S_CLEAR;
            S_CLEAR: if (gnt_clr && clr_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // wr_ack in the grant term keeps a still-held request from being served twice.
    always_comb begin
        busy     = (state == S_CLEAR);
        gnt_disp = disp_req;
        gnt_clr  = !disp_req && (state == S_CLEAR);
        gnt_host = !disp_req && (state == S_IDLE) && wr_req && !wr_ack;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            ram_we <= 1'b0;
            if (gnt_disp) begin
                ram_addr <= disp_addr;
            end else if (gnt_clr) begin
                ram_addr  <= clr_cnt;
                ram_we    <= 1'b1;
                ram_wdata <= CLR_CHAR;
            end else if (gnt_host) begin
                ram_addr  <= wr_addr;
                ram_we    <= wr_in_range;
                ram_wdata <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt  <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= gnt_clr && clr_last;
            if ((state == S_IDLE) && clr_start) begin
                clr_cnt <= '0;
            end else if (gnt_clr) begin
                clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= gnt_host;
            wr_err <= gnt_host && !wr_in_range;
        end
    end

    // Out-of-range tiles still occupy a read slot so output timing never shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v1    <= 1'b0;
            pipe_v2    <= 1'b0;
            pipe_oob1  <= 1'b0;
            pipe_oob2  <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            pipe_v1    <= disp_req;
            pipe_oob1  <= disp_oob;
            pipe_v2    <= pipe_v1;
            pipe_oob2  <= pipe_oob1;
            disp_valid <= pipe_v2;
            disp_data  <= (pipe_v2 && !pipe_oob2) ? ram_rdata : '0;
        end
    end

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Directed bench for text_ram_arbiter with a behavioural sync RAM, a shadow memory model
// and a queue scoreboard for display reads.
module tb_text_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_req;
    logic [5:0]  disp_col;
    logic [5:0]  disp_row;
    logic        disp_valid;
    logic [6:0]  disp_data;
    logic        wr_req;
    logic [10:0] wr_addr;
    logic [6:0]  wr_data;
    logic        wr_ack;
    logic        wr_err;
    logic        clr_start;
    logic        busy;
    logic        clr_done;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [6:0]  ram_wdata;
    logic [6:0]  ram_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    text_ram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .disp_req   (disp_req),
        .disp_col   (disp_col),
        .disp_row   (disp_row),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .clr_start  (clr_start),
        .busy       (busy),
        .clr_done   (clr_done),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    function automatic logic [6:0] pat(input logic [10:0] a);
        if (a == 11'd83) return 7'h41;
        return 7'(32'(a) * 5 + 1);
    endfunction

    // Behavioural synchronous RAM, preloaded through its own port while preload is high.
    logic [6:0]  mem [2048];
    logic        preload = 1'b1;
    logic [10:0] load_idx = '0;

    always @(posedge clk) begin
        if (preload) begin
            mem[load_idx] <= pat(load_idx);
            load_idx      <= load_idx + 11'd1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    logic [6:0] shadow [2048];

    typedef struct {
        int         due;
        logic [6:0] data;
    } sb_t;
    sb_t q[$];

    logic clr_mon = 1'b0;
    int   clr_exp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                check("disp_valid", 32'(disp_valid), 32'd1);
                check("disp_data", 32'(disp_data), 32'(q[0].data));
                void'(q.pop_front());
            end else if (disp_valid) begin
                check("disp_valid_spurious", 32'(disp_valid), 32'd0);
            end
            if (ram_we) check("we_addr_in_range", 32'(ram_addr < 11'd1600), 32'd1);
            if (clr_mon && ram_we) begin
                check("clr_addr", 32'(ram_addr), 32'(clr_exp));
                check("clr_wdata", 32'(ram_wdata), 32'h20);
                clr_exp++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_char(input int c, input int r);
        if (c >= 40 || r >= 40) return 7'h00;
        return shadow[11'(r * 40 + c)];
    endfunction

    task automatic issue_read(input int c, input int r);
        sb_t e;
        disp_req = 1'b1;
        disp_col = 6'(c);
        disp_row = 6'(r);
        e.due    = cyc + 3;
        e.data   = exp_char(c, r);
        q.push_back(e);
    endtask

    // Runs from the first busy cycle until clr_done, optionally injecting display reads.
    task automatic run_clear(input int every, input int exp_busy, input string tag);
        int busy_cnt = 0;
        int ndisp    = 0;
        int fin      = 0;
        for (int k = 0; k < 5000 && fin == 0; k++) begin
            disp_req = 1'b0;
            if (busy) busy_cnt++;
            if (busy && wr_req) check({tag, "_hold_ack"}, 32'(wr_ack), 32'd0);
            if (clr_done) begin
                fin = 1;
                check({tag, "_done_busy_low"}, 32'(busy), 32'd0);
            end else begin
                if (every > 0 && busy && (k % every) == 0) begin
                    issue_read(50, 0);
                    ndisp++;
                end
                tick();
            end
        end
        disp_req = 1'b0;
        check({tag, "_finished"}, 32'(fin), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy + ndisp));
        tick();
        clr_mon = 1'b0;
        check({tag, "_done_single"}, 32'(clr_done), 32'd0);
        check({tag, "_write_count"}, 32'(clr_exp), 32'd1600);
        for (int i = 0; i < 2048; i++) shadow[i] = (i < 1600) ? 7'h20 : shadow[i];
    endtask

    initial begin
        int got;
        int ack_k;
        rst       = 1'b1;
        disp_req  = 1'b0;
        disp_col  = '0;
        disp_row  = '0;
        wr_req    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clr_start = 1'b0;
        for (int i = 0; i < 2048; i++) shadow[i] = pat(11'(i));
        repeat (2048) @(posedge clk);
        #1;
        preload = 1'b0;
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        rst = 1'b0;
        tick();
        tick();

        // Display latency and back-to-back throughput, including out-of-range tiles
        issue_read(3, 2);
        tick();
        check("disp_ram_addr", 32'(ram_addr), 32'd83);
        check("disp_ram_we", 32'(ram_we), 32'd0);
        for (int i = 0; i < 8; i++) begin
            issue_read(i + 30, 39);
            tick();
        end
        issue_read(45, 0);
        tick();
        issue_read(0, 41);
        tick();
        disp_req = 1'b0;
        repeat (5) tick();

        // Host write in range, then read back
        wr_req  = 1'b1;
        wr_addr = 11'd5;
        wr_data = 7'h42;
        tick();
        check("hw_ram_we", 32'(ram_we), 32'd1);
        check("hw_ram_addr", 32'(ram_addr), 32'd5);
        check("hw_ram_wdata", 32'(ram_wdata), 32'h42);
        check("hw_ack", 32'(wr_ack), 32'd1);
        check("hw_err", 32'(wr_err), 32'd0);
        wr_req    = 1'b0;
        shadow[5] = 7'h42;
        tick();
        check("hw_ack_single", 32'(wr_ack), 32'd0);
        issue_read(5, 0);
        tick();
        disp_req = 1'b0;
        repeat (4) tick();

        // Host write out of range
        wr_req  = 1'b1;
        wr_addr = 11'd1600;
        wr_data = 7'h11;
        tick();
        check("oob_ack", 32'(wr_ack), 32'd1);
        check("oob_err", 32'(wr_err), 32'd1);
        check("oob_ram_we", 32'(ram_we), 32'd0);
        wr_req = 1'b0;
        tick();
        check("oob_ack_single", 32'(wr_ack), 32'd0);
        check("oob_err_single", 32'(wr_err), 32'd0);

        // Display holds off a pending host write for 20 cycles
        wr_req  = 1'b1;
        wr_addr = 11'd10;
        wr_data = 7'h55;
        for (int i = 0; i < 20; i++) begin
            issue_read(i, 3);
            tick();
            check("cont_no_ack", 32'(wr_ack), 32'd0);
        end
        disp_req = 1'b0;
        got      = 0;
        ack_k    = -1;
        for (int k = 0; k < 3 && got == 0; k++) begin
            tick();
            if (wr_ack) begin
                got   = 1;
                ack_k = k;
            end
        end
        check("cont_ack_seen", 32'(got), 32'd1);
        check("cont_ack_latency", 32'(ack_k >= 0 && ack_k <= 1), 32'd1);
        check("cont_ram_addr", 32'(ram_addr), 32'd10);
        check("cont_ram_we", 32'(ram_we), 32'd1);
        wr_req     = 1'b0;
        shadow[10] = 7'h55;
        issue_read(10, 0);
        tick();
        disp_req = 1'b0;
        repeat (4) tick();

        // Full clear without display traffic
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        clr_exp   = 0;
        clr_mon   = 1'b1;
        run_clear(0, 1600, "clr_plain");
        issue_read(0, 0);
        tick();
        issue_read(39, 39);
        tick();
        issue_read(3, 2);
        tick();
        disp_req = 1'b0;
        repeat (4) tick();

        // Clear with display every 4th cycle
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        clr_exp   = 0;
        clr_mon   = 1'b1;
        run_clear(4, 1600, "clr_disp");
        repeat (5) tick();

        // Reset mid-clear
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        clr_exp   = 0;
        clr_mon   = 1'b1;
        for (int k = 0; k < 2000 && clr_exp < 700; k++) tick();
        check("mid_reached_700", 32'(clr_exp >= 700), 32'd1);
        rst = 1'b1;
        #1;
        clr_mon = 1'b0;
        q.delete();
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_clr_done", 32'(clr_done), 32'd0);
        check("mid_ram_addr", 32'(ram_addr), 32'd0);
        check("mid_ram_we", 32'(ram_we), 32'd0);
        check("mid_ram_wdata", 32'(ram_wdata), 32'd0);
        check("mid_wr_ack", 32'(wr_ack), 32'd0);
        check("mid_wr_err", 32'(wr_err), 32'd0);
        check("mid_disp_valid", 32'(disp_valid), 32'd0);
        check("mid_disp_data", 32'(disp_data), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        got = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (clr_done || busy) got = 1;
        end
        check("mid_no_done_after_rst", 32'(got), 32'd0);

        // Restart: clr_start together with a host write; another write held through the sweep
        clr_start = 1'b1;
        wr_req    = 1'b1;
        wr_addr   = 11'd7;
        wr_data   = 7'h11;
        tick();
        clr_start = 1'b0;
        check("sim_ack", 32'(wr_ack), 32'd1);
        check("sim_ram_we", 32'(ram_we), 32'd1);
        check("sim_ram_addr", 32'(ram_addr), 32'd7);
        check("sim_busy", 32'(busy), 32'd1);
        wr_req = 1'b0;
        tick();
        clr_exp = 0;
        clr_mon = 1'b1;
        repeat (10) tick();
        wr_req  = 1'b1;
        wr_addr = 11'd9;
        wr_data = 7'h33;
        run_clear(0, 1599 - 10, "clr_restart");
        got = int'(wr_ack);
        for (int k = 0; k < 3 && got == 0; k++) begin
            tick();
            if (wr_ack) got = 1;
        end
        check("held_ack_after_clear", 32'(got), 32'd1);
        check("held_ram_addr", 32'(ram_addr), 32'd9);
        check("held_ram_wdata", 32'(ram_wdata), 32'h33);
        wr_req    = 1'b0;
        shadow[9] = 7'h33;
        tick();
        issue_read(9, 0);
        tick();
        issue_read(7, 0);
        tick();
        issue_read(45, 45);
        tick();
        disp_req = 1'b0;
        repeat (6) tick();
        check("sb_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_ram_arbiter.md
Name: text_ram_arbiter

Overview:
- Shares the single-port character RAM of the text overlay between three requesters: the display fetch path, which converts pixel tile coordinates into character reads; a host write port; and an internal screen-clear sequencer.
- Fixed priority is display > clear > host.
- The display path gets a fixed read latency, so downstream glyph lookup stays pixel-aligned.
- Sits between the tile-coordinate stage and the character ROM lookup.

Parameters:
- COLS, 40, characters per row.
- ROWS, 40, character rows.
- ADDR_W, 11, RAM address width. Must satisfy 2^ADDR_W >= COLS*ROWS.
- DATA_W, 7, character code width.
- CLR_CHAR, 7'h20, code written by the clear sweep.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- disp_req  in  1  display read request, sampled every cycle.
- disp_col  in  6  tile column.
- disp_row  in  6  tile row.
- disp_valid  out  1  disp_data valid strobe.
- disp_data  out  DATA_W  character read for the request issued 3 cycles earlier.
- wr_req  in  1  host write request, level; held with wr_addr/wr_data until wr_ack.
- wr_addr  in  ADDR_W  host linear address.
- wr_data  in  DATA_W  host character.
- wr_ack  out  1  one-cycle acknowledge.
- wr_err  out  1  pulses with wr_ack when wr_addr >= COLS*ROWS.
- clr_start  in  1  one-cycle pulse requesting a full-screen clear.
- busy  out  1  high while the clear sweep is active.
- clr_done  out  1  one-cycle pulse after the last clear write is issued.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_rdata  in  DATA_W  RAM read data; synchronous RAM, valid 1 cycle after address.

Behaviour:
- Reset (async, any time):
  - All outputs to 0. FSM to IDLE. Clear counter to 0. Valid pipeline flushed.
  - A clear interrupted by reset is abandoned; no clr_done.
- Display address:
  - disp_addr = disp_row*COLS + disp_col, computed in ADDR_W bits.
  - col >= COLS or row >= ROWS: the request is still served (pipeline timing is preserved) but disp_data is forced to 0.
- Grant: evaluated every cycle from sampled inputs; the winner's address/we/data are registered onto the ram_* ports at that edge.
  1. disp_req=1: read; ram_we=0.
  2. Else state CLEAR: write CLR_CHAR at clr_cnt, then clr_cnt++.
  3. Else state IDLE and wr_req=1 and wr_ack=0: host write. ram_we=1 only if the address is in range. wr_ack=1 next cycle; wr_err=1 next cycle if out of range.
  4. Else: ram_we=0, ram_addr holds.
- Host handshake:
  - The requester deasserts wr_req or changes the address in the cycle wr_ack is seen.
  - wr_req still high in the ack cycle is not granted again in that cycle (the wr_ack=0 term). Back-to-back writes therefore sustain at most 1 per 2 cycles.
- Display latency:
  - Request sampled in cycle N.
  - ram_addr presented in N+1.
  - ram_rdata valid in N+2, registered.
  - disp_valid=1 with disp_data in N+3.
  - Requests may be issued every cycle; throughput is 1/cycle.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start: clr_cnt=0, busy=1 from the next cycle.
  - CLEAR -> IDLE after the write to address COLS*ROWS-1 is issued: clr_done pulses the same cycle busy falls.
  - clr_start while in CLEAR is ignored.
  - wr_req is held without ack during CLEAR and served after return to IDLE.
  - Clear writes stall on each disp_req cycle; clr_cnt advances only on granted writes.
- Simultaneous clr_start and wr_req in IDLE: the host write is granted that cycle, and the clear begins the next cycle.

Test Plan:
- Display latency: disp_req=1 with col=3,row=2 (addr 83, RAM holds 'A') in cycle 10 -> ram_addr=83 in cycle 11; disp_valid=1, disp_data=7'h41 in cycle 13; continuous requests give 1 result per cycle.
- Host write: wr_req=1, addr=5, data=7'h42 with display idle -> ram_we=1, ram_addr=5, ram_wdata=7'h42 next cycle; wr_ack pulses once; wr_err=0. A following read of addr 5 returns 7'h42.
- Out-of-range host write: addr=1600 -> wr_ack=1 and wr_err=1; ram_we never 1.
- Contention: disp_req held high for 20 cycles while wr_req=1 -> no wr_ack during those 20 cycles; write granted and wr_ack on the 1st/2nd cycle after disp_req falls.
- Clear: clr_start with no display traffic -> 1600 writes of 7'h20 to addresses 0..1599 in order; busy high 1600 cycles; clr_done single pulse. With disp_req asserted every 4th cycle, completion is delayed by exactly the number of display cycles and no address is skipped.
- Reset mid-clear: rst at clr_cnt=700 -> busy=0, all outputs 0 immediately, no clr_done; a new clr_start restarts from address 0.
